// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns raw PS/2 receive-stage frames (Set-2 scancodes) into key events.
//   Strips the E0 (extended) and F0 (break) prefixes, checks parity and
//   stop bit, tracks Shift / Caps Lock, maps a subset of keys to ASCII and
//   queues the resulting events in a small FIFO.
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-low
//   frame_done   receive-stage done flag; a frame is taken on its rising edge
//   frame[9:0]   [7:0] data byte, [8] odd parity, [9] stop bit
//   ev_rd        pop head event (ignored while ev_valid=0)
//   ev_valid     FIFO non-empty
//   ev_code      head event scancode (prefixes stripped)
//   ev_ext       head event was E0-prefixed
//   ev_release   head event is a break
//   ev_ascii     head event ASCII, 0x00 if unmapped
//   shift_held   left or right Shift currently down
//   caps_on      Caps Lock toggle state
//   err_parity   one-cycle pulse on a bad-parity frame
//   err_frame    one-cycle pulse on bad stop bit or data byte 0x00/0xFF
//   overflow     sticky, set when an event is dropped
module ps2_scancode_decoder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_done,
    input  logic [9:0] frame,
    input  logic       ev_rd,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic [7:0] ev_ascii,
    output logic       shift_held,
    output logic       caps_on,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Set-2 scancode to ASCII; letters are upper-cased when requested.
    function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        c = 8'h00;
        case (code)
            8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
            8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
            8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
            8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
            8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
            8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
            8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
            8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
            8'h3E: c = 8'h38; 8'h46: c = 8'h39;
            8'h29: c = 8'h20;
            8'h5A: c = 8'h0D;
            8'h66: c = 8'h08;
            default: c = 8'h00;
        endcase
        if (upper && (c >= 8'h61) && (c <= 8'h7A)) begin
            c = c - 8'h20;
        end
        return c;
    endfunction

    // ---- stage p0: frame accept, checks, prefix FSM ----
    logic         frame_done_p0;
    logic         accept;
    logic [7:0]   byte_in;
    logic         parity_ok;
    logic         stop_ok;
    logic         good;
    logic         bad_parity;
    logic         bad_frame;
    state_t       state, state_nx;
    logic [CW-1:0] tmo_cnt_p0;
    logic         tmo_expire;
    logic         push_req;
    logic         push_ext;
    logic         push_rel;
    logic [7:0]   push_ascii;
    logic [17:0]  push_entry;
    logic         shift_l, shift_r, caps_held;

    assign accept     = frame_done & ~frame_done_p0;
    assign byte_in    = frame[7:0];
    assign parity_ok  = ^frame[8:0];
    assign stop_ok    = frame[9] && (byte_in != 8'h00) && (byte_in != 8'hFF);
    assign bad_parity = accept & ~parity_ok;
    assign bad_frame  = accept & parity_ok & ~stop_ok;
    assign good       = accept & parity_ok & stop_ok;
    assign tmo_expire = (state != IDLE) && (tmo_cnt_p0 == TMO_LAST);

    always_comb begin
        state_nx = state;
        push_req = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        if (good) begin
            case (state)
                IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_nx = EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_nx = BRK;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_nx = EXT_BRK;
                    end else if (byte_in != 8'hE0) begin
                        push_req = 1'b1;
                        push_ext = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    push_req = 1'b1;
                    push_rel = 1'b1;
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    push_req = 1'b1;
                    push_ext = 1'b1;
                    push_rel = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (accept) begin
            state_nx = IDLE;
        end else if (tmo_expire) begin
            // A frame arriving in the expiry cycle takes the branches above.
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            // Primed high so a level already up at reset release is not a frame.
            frame_done_p0 <= 1'b1;
            tmo_cnt_p0    <= '0;
            err_parity    <= 1'b0;
            err_frame     <= 1'b0;
        end else begin
            state         <= state_nx;
            frame_done_p0 <= frame_done;
            err_parity    <= bad_parity;
            err_frame     <= bad_frame;
            if (accept) begin
                tmo_cnt_p0 <= '0;
            end else if (state != IDLE) begin
                tmo_cnt_p0 <= tmo_cnt_p0 + 1'b1;
            end
        end
    end

    // ASCII uses the modifier state before this event's own update.
    assign shift_held = shift_l | shift_r;
    assign push_ascii = (push_ext | push_rel) ? 8'h00 : ascii_map(byte_in, shift_held ^ caps_on);
    assign push_entry = {push_ext, push_rel, byte_in, push_ascii};

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_on   <= 1'b0;
            caps_held <= 1'b0;
        end else if (push_req && !push_ext) begin
            case (byte_in)
                8'h12: shift_l <= ~push_rel;
                8'h59: shift_r <= ~push_rel;
                8'h58: begin
                    if (push_rel) begin
                        caps_held <= 1'b0;
                    end else begin
                        // Typematic repeats keep caps_held set and do not retoggle.
                        if (!caps_held) begin
                            caps_on <= ~caps_on;
                        end
                        caps_held <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- stage p1: event FIFO ----
    logic [17:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok;
    logic [17:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == FULL_CNT);
    assign pop     = ev_rd & ~empty;
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign ev_valid   = ~empty;
    assign ev_ext     = ev_valid & head[17];
    assign ev_release = ev_valid & head[16];
    assign ev_code    = ev_valid ? head[15:8] : 8'h00;
    assign ev_ascii   = ev_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed scenarios plus randomized
// frame streams checked against an event-level reference model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_done = 1'b1;
    logic [9:0] frame = '0;
    logic       ev_rd = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic [7:0] ev_ascii;
    logic       shift_held;
    logic       caps_on;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .frame_done(frame_done), .frame(frame),
        .ev_rd(ev_rd), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_release(ev_release), .ev_ascii(ev_ascii), .shift_held(shift_held),
        .caps_on(caps_on), .err_parity(err_parity), .err_frame(err_frame),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
        logic [7:0] ascii;
    } ev_t;

    ev_t mq[$];
    bit  m_shl, m_shr, m_caps, m_caps_held, m_ovf, m_pext, m_pbrk;
    int  m_last = 0;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};

    function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++)
            if (letters[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_shl = 0; m_shr = 0; m_caps = 0; m_caps_held = 0;
        m_ovf = 0; m_pext = 0; m_pbrk = 0;
    endtask

    task automatic m_push(input bit ext, input bit rel, input logic [7:0] code);
        ev_t e;
        e.ext   = ext;
        e.rel   = rel;
        e.code  = code;
        e.ascii = (ext || rel) ? 8'h00 : m_ascii(code, (m_shl | m_shr) ^ m_caps);
        if (!ext) begin
            if (code == 8'h12) m_shl = !rel;
            if (code == 8'h59) m_shr = !rel;
            if (code == 8'h58) begin
                if (rel) m_caps_held = 0;
                else begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end
            end
        end
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit pgood, input bit stop,
                               input int acc, output bit perr, output bit ferr);
        if ((m_pext || m_pbrk) && (acc - m_last > TIMEOUT)) begin
            m_pext = 0;
            m_pbrk = 0;
        end
        m_last = acc;
        perr = !pgood;
        ferr = pgood && (!stop || b == 8'h00 || b == 8'hFF);
        if (perr || ferr) begin
            m_pext = 0;
            m_pbrk = 0;
        end else if (m_pbrk) begin
            m_push(m_pext, 1, b);
            m_pext = 0;
            m_pbrk = 0;
        end else if (b == 8'hE0) begin
            m_pext = 1;
        end else if (b == 8'hF0) begin
            m_pbrk = 1;
        end else begin
            m_push(m_pext, 0, b);
            m_pext = 0;
        end
    endtask

    // ---------------- bench tasks ----------------
    task automatic compare_state();
        chk("ev_valid", ev_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("ev_code", ev_code, mq[0].code);
            chk("ev_ext", ev_ext, mq[0].ext);
            chk("ev_release", ev_release, mq[0].rel);
            chk("ev_ascii", ev_ascii, mq[0].ascii);
        end
        chk("shift_held", shift_held, m_shl | m_shr);
        chk("caps_on", caps_on, m_caps);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic send(input logic [7:0] b, input bit pgood = 1, input bit stop = 1,
                        input bit pop = 0);
        bit perr, ferr;
        @(negedge clk);
        frame      = {stop, pgood ? ~(^b) : ^b, b};
        frame_done = 1'b1;
        ev_rd      = pop;
        @(negedge clk);
        frame_done = 1'b0;
        ev_rd      = 1'b0;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        model_frame(b, pgood, stop, cyc, perr, ferr);
        chk("err_parity", err_parity, perr);
        chk("err_frame", err_frame, ferr);
        compare_state();
    endtask

    task automatic pop_ev();
        @(negedge clk);
        ev_rd = 1'b1;
        @(negedge clk);
        ev_rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        compare_state();
    endtask

    task automatic drain();
        int n;
        n = mq.size();
        repeat (n) pop_ev();
        chk("drain_empty", ev_valid, 0);
    endtask

    task automatic do_reset(input logic fd);
        @(negedge clk);
        reset      = 1'b0;
        frame_done = fd;
        @(negedge clk);
        m_clear();
        chk("rst_valid", ev_valid, 0);
        chk("rst_shift", shift_held, 0);
        chk("rst_caps", caps_on, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        frame_done = 1'b0;
        @(negedge clk);
        chk("rst_no_event", ev_valid, 0);
    endtask

    initial begin
        bit perr, ferr;
        m_clear();
        // Reset with frame_done already high: that level must not count.
        repeat (3) @(negedge clk);
        chk("init_valid", ev_valid, 0);
        chk("init_code", ev_code, 0);
        chk("init_ascii", ev_ascii, 0);
        chk("init_flags", {ev_ext, ev_release, shift_held, caps_on, err_parity, err_frame, overflow}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("primed_edge", ev_valid, 0);
        frame_done = 1'b0;

        // Make then break of 'a'
        send(8'h1C);
        chk("a_make_ascii", ev_ascii, 8'h61);
        pop_ev();
        send(8'hF0); send(8'h1C);
        chk("a_break_rel", ev_release, 1);
        chk("a_break_ascii", ev_ascii, 8'h00);
        drain();

        // Shift
        send(8'h12); pop_ev();
        send(8'h1C);
        chk("shift_A", ev_ascii, 8'h41);
        pop_ev();
        send(8'hF0); send(8'h12); pop_ev();
        chk("shift_released", shift_held, 0);
        send(8'h1C);
        chk("unshift_a", ev_ascii, 8'h61);
        drain();

        // Caps Lock with typematic repeats
        send(8'h58); chk("caps_on1", caps_on, 1);
        send(8'h58); send(8'h58); chk("caps_repeat", caps_on, 1);
        drain();
        send(8'hF0); send(8'h58); chk("caps_after_brk", caps_on, 1);
        send(8'h58); chk("caps_off", caps_on, 0);
        drain();

        // Extended break
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("extbrk_code", ev_code, 8'h75);
        chk("extbrk_flags", {ev_ext, ev_release}, 2'b11);
        chk("extbrk_count", mq.size(), 1);
        drain();

        // Prefix timeout, well past and right at the boundary
        send(8'hE0); repeat (TIMEOUT + 5) @(negedge clk);
        send(8'h1C); chk("tmo_ext_cleared", ev_ext, 0);
        drain();
        send(8'hE0); repeat (TIMEOUT - 2) @(negedge clk);
        send(8'h75); chk("tmo_frame_wins", ev_ext, 1);
        drain();
        send(8'hE0); repeat (TIMEOUT - 1) @(negedge clk);
        send(8'h75); chk("tmo_just_expired", ev_ext, 0);
        drain();

        // Parity and framing errors
        send(8'h1C, 0);
        chk("perr_pulse", err_parity, 1);
        @(negedge clk);
        chk("perr_one_cycle", err_parity, 0);
        chk("perr_no_event", ev_valid, 0);
        send(8'hF0); send(8'h15, 1, 0);
        chk("ferr_pulse", err_frame, 1);
        send(8'h15); chk("ferr_then_make", ev_release, 0);
        drain();

        // Overflow with no pops
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", ev_code, 8'h1C);
        drain();
        do_reset(1'b0);
        // Full push with a pop in the same cycle
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        send(8'h24, 1, 1, 1);
        chk("ovf_pop_clear", overflow, 0);
        chk("ovf_pop_head", ev_code, 8'h32);
        drain();

        // frame_done held high for 20 cycles
        @(negedge clk);
        frame      = {1'b1, ~(^8'h2D), 8'h2D};
        frame_done = 1'b1;
        @(negedge clk);
        model_frame(8'h2D, 1, 1, cyc, perr, ferr);
        repeat (19) @(negedge clk);
        frame_done = 1'b0;
        @(negedge clk);
        compare_state();
        chk("hold_one_event", mq.size(), 1);
        drain();

        // Randomized frame stream
        for (int i = 0; i < 300; i++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 19);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = 8'h12;
            else if (r == 5) b = 8'h59;
            else if (r == 6) b = 8'h58;
            else if (r < 14) b = letters[$urandom_range(0, 25)];
            else if (r < 16) b = digits[$urandom_range(0, 9)];
            else if (r == 16) b = ($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A;
            else b = 8'($urandom_range(0, 255));
            send(b, $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) pop_ev();
            if ($urandom_range(0, 29) == 0) repeat (TIMEOUT + 3) @(negedge clk);
        end
        drain();

        // Mid-operation reset with events queued and modifiers active
        do_reset(1'b0);
        send(8'h12); send(8'h58); send(8'h1C);
        chk("pre_rst_count", mq.size(), 3);
        chk("pre_rst_mods", {shift_held, caps_on}, 2'b11);
        send(8'hE0);
        do_reset(1'b0);
        send(8'h75);
        chk("post_rst_no_prefix", ev_ext, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
